throw_scheduler: RTL

THROW_SCHEDULER -- requirements
Module: throw_scheduler

---
 rtl/throw_scheduler.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/throw_scheduler.sv
// Juggling siteswap scheduler: on each beat it throws the ball due in the current
// landing slot (or introduces a new one) and books its landing in an 8-slot ring.
module throw_scheduler (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            new_beat,
    input  logic [6:0][2:0] pattern_in,
    input  logic [2:0]      pattern_length,
    input  logic [2:0]      num_balls_in,
    input  logic            pattern_valid_in,
    output logic            throw_valid_out,
    output logic [2:0]      throw_height_out,
    output logic            ball_valid_out,
    output logic [2:0]      ball_id_out,
    output logic            hand_out,
    output logic [2:0]      beat_index_out,
    output logic            error_out
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_q, state_d;
    logic            pv_prev_q, pv_prev_d;
    logic [6:0][2:0] pat_q, pat_d;
    logic [2:0]      len_q, len_d;
    logic [2:0]      nb_q, nb_d;
    logic [2:0]      idx_q, idx_d;
    logic [2:0]      cur_q, cur_d;
    logic [2:0]      nnb_q, nnb_d;
    logic            hand_q, hand_d;
    logic [7:0]      occ_q, occ_d;
    logic [7:0][2:0] ids_q, ids_d;
    logic            tv_q, tv_d;
    logic [2:0]      th_q, th_d;
    logic            bv_q, bv_d;
    logic [2:0]      bid_q, bid_d;
    logic            hout_q, hout_d;
    logic [2:0]      bidx_q, bidx_d;
    logic            err_q, err_d;

    logic            pv_rise;
    logic [2:0]      h;
    logic [2:0]      target;
    logic            throw_ok;
    logic [2:0]      throw_id;

    assign pv_rise = pattern_valid_in && !pv_prev_q;
    assign h       = pat_q[idx_q];
    assign target  = cur_q + h;

    always_comb begin
        state_d   = state_q;
        pv_prev_d = pattern_valid_in;
        pat_d     = pat_q;
        len_d     = len_q;
        nb_d      = nb_q;
        idx_d     = idx_q;
        cur_d     = cur_q;
        nnb_d     = nnb_q;
        hand_d    = hand_q;
        occ_d     = occ_q;
        ids_d     = ids_q;
        tv_d      = 1'b0;
        th_d      = th_q;
        bv_d      = bv_q;
        bid_d     = bid_q;
        hout_d    = hout_q;
        bidx_d    = bidx_q;
        err_d     = err_q;
        throw_ok  = 1'b0;
        throw_id  = 3'd0;

        // A load always wins over a coincident beat
        if (pv_rise) begin
            state_d = RUN;
            pat_d   = pattern_in;
            len_d   = pattern_length;
            nb_d    = num_balls_in;
            idx_d   = 3'd0;
            cur_d   = 3'd0;
            nnb_d   = 3'd0;
            hand_d  = 1'b0;
            occ_d   = '0;
            ids_d   = '0;
            err_d   = 1'b0;
        end else if (state_q == RUN) begin
            if (!pattern_valid_in) begin
                state_d = IDLE;
                occ_d   = '0;
            end else if (new_beat) begin
                if (h != 3'd0) begin
                    if (occ_q[cur_q]) begin
                        throw_ok     = 1'b1;
                        throw_id     = ids_q[cur_q];
                        occ_d[cur_q] = 1'b0;
                    end else if (nnb_q < nb_q) begin
                        throw_ok = 1'b1;
                        throw_id = nnb_q;
                        nnb_d    = nnb_q + 3'd1;
                    end else begin
                        err_d = 1'b1;
                    end
                    // h is 1..7 so the target never aliases the slot just vacated
                    if (throw_ok) begin
                        if (occ_q[target]) begin
                            err_d = 1'b1;
                        end
                        occ_d[target] = 1'b1;
                        ids_d[target] = throw_id;
                    end
                end else if (occ_q[cur_q]) begin
                    err_d = 1'b1;
                end

                tv_d   = 1'b1;
                th_d   = h;
                bv_d   = throw_ok;
                if (throw_ok) begin
                    bid_d = throw_id;
                end
                hout_d = hand_q;
                bidx_d = idx_q;

                cur_d  = cur_q + 3'd1;
                hand_d = !hand_q;
                if (((idx_q + 3'd1) >= len_q) || (idx_q == 3'd6)) begin
                    idx_d = 3'd0;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= IDLE;
            pv_prev_q <= 1'b0;
            pat_q     <= '0;
            len_q     <= 3'd0;
            nb_q      <= 3'd0;
            idx_q     <= 3'd0;
            cur_q     <= 3'd0;
            nnb_q     <= 3'd0;
            hand_q    <= 1'b0;
            occ_q     <= '0;
            ids_q     <= '0;
            tv_q      <= 1'b0;
            th_q      <= 3'd0;
            bv_q      <= 1'b0;
            bid_q     <= 3'd0;
            hout_q    <= 1'b0;
            bidx_q    <= 3'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pv_prev_q <= pv_prev_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            nb_q      <= nb_d;
            idx_q     <= idx_d;
            cur_q     <= cur_d;
            nnb_q     <= nnb_d;
            hand_q    <= hand_d;
            occ_q     <= occ_d;
            ids_q     <= ids_d;
            tv_q      <= tv_d;
            th_q      <= th_d;
            bv_q      <= bv_d;
            bid_q     <= bid_d;
            hout_q    <= hout_d;
            bidx_q    <= bidx_d;
            err_q     <= err_d;
        end
    end

    assign throw_valid_out  = tv_q;
    assign throw_height_out = th_q;
    assign ball_valid_out   = bv_q;
    assign ball_id_out      = bid_q;
    assign hand_out         = hout_q;
    assign beat_index_out   = bidx_q;
    assign error_out        = err_q;

endmodule
